// File: rtl/change_dispenser.sv
// Coin-return controller: latches credit/price on start, then pays the change
// out largest-coin-first over a 4-phase req/ack handshake with the ejector.
module change_dispenser #(
    parameter logic [7:0] COIN0       = 8'd50,
    parameter logic [7:0] COIN1       = 8'd25,
    parameter logic [7:0] COIN2       = 8'd10,
    parameter logic [7:0] COIN3       = 8'd5,
    parameter logic [7:0] COIN4       = 8'd1,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] credit,
    input  logic [7:0] price,
    input  logic       coin_ack,
    output logic       coin_req,
    output logic [2:0] coin_sel,
    output logic [7:0] remaining,
    output logic       busy,
    output logic       done,
    output logic       insufficient,
    output logic       fault
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CHECK    = 3'd1;
    localparam logic [2:0] S_SELECT   = 3'd2;
    localparam logic [2:0] S_REQ      = 3'd3;
    localparam logic [2:0] S_WAIT_REL = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;
    localparam logic [2:0] S_ERR      = 3'd6;
    localparam logic [2:0] S_FAULT    = 3'd7;

    localparam int             CW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [4:0][7:0] COIN_TAB = {COIN4, COIN3, COIN2, COIN1, COIN0};

    logic [2:0]    state;
    logic [7:0]    credit_q, price_q;
    logic [CW-1:0] tmo_cnt;
    logic [4:0]    fits;
    logic [2:0]    pick;

    for (genvar i = 0; i < 5; i++) begin : g_fit
        assign fits[i] = (COIN_TAB[i] <= remaining);
    end

    // Lowest index wins; COIN4 == 1 guarantees a hit whenever remaining != 0.
    always_comb begin
        pick = 3'd4;
        for (int i = 4; i >= 0; i--)
            if (fits[i]) pick = 3'(i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            credit_q     <= '0;
            price_q      <= '0;
            tmo_cnt      <= '0;
            coin_req     <= 1'b0;
            coin_sel     <= '0;
            remaining    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            insufficient <= 1'b0;
            fault        <= 1'b0;
        end else begin
            done         <= 1'b0;
            insufficient <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    credit_q <= credit;
                    price_q  <= price;
                    fault    <= 1'b0;
                    busy     <= 1'b1;
                    state    <= S_CHECK;
                end
                S_CHECK: if (credit_q < price_q) begin
                    remaining    <= '0;
                    insufficient <= 1'b1;
                    state        <= S_ERR;
                end else begin
                    remaining <= credit_q - price_q;
                    state     <= S_SELECT;
                end
                S_SELECT: if (remaining == '0) begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end else begin
                    coin_sel <= pick;
                    coin_req <= 1'b1;
                    tmo_cnt  <= '0;
                    state    <= S_REQ;
                end
                S_REQ: if (coin_ack) begin
                    remaining <= remaining - COIN_TAB[coin_sel];
                    coin_req  <= 1'b0;
                    state     <= S_WAIT_REL;
                end else if (tmo_cnt == TMO_LAST) begin
                    coin_req <= 1'b0;
                    fault    <= 1'b1;
                    state    <= S_FAULT;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
                // Holding here until ack drops keeps the handshake 4-phase.
                S_WAIT_REL: if (!coin_ack) state <= S_SELECT;
                S_DONE: begin
                    remaining <= '0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                S_ERR, S_FAULT: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    coin_req <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Coin-return controller for the vending datapath; the paying-out counterpart of the credit accumulator.
- On a `start` request it latches the accumulated credit and the product price, and computes the change.
- It pays the change out one coin at a time through a req/ack handshake with the coin-ejector mechanism, largest denomination first.
- It reports completion, insufficient credit, or an ejector fault.

Parameters:
- COIN0, 50, value of denomination 0 (largest)
- COIN1, 25, value of denomination 1
- COIN2, 10, value of denomination 2
- COIN3, 5, value of denomination 3
- COIN4, 1, value of denomination 4 (must be 1 so any change is payable)
- ACK_TIMEOUT, 16, max cycles `coin_req` may wait for `coin_ack` before fault

Ports:
- clk  in  1  clock, rising-edge active
- rst  in  1  asynchronous, active-low reset
- start  in  1  dispense request, level-sampled only in IDLE
- credit  in  8  unsigned accumulated credit, sampled with start
- price  in  8  unsigned product price, sampled with start
- coin_ack  in  1  ejector acknowledge: coin physically released
- coin_req  out  1  request to eject one coin of type coin_sel
- coin_sel  out  3  denomination index 0..4, stable while coin_req=1
- remaining  out  8  change still to be paid
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: all change paid
- insufficient  out  1  one-cycle pulse: credit < price, nothing paid
- fault  out  1  sticky ejector timeout flag, cleared by next accepted start or reset

Behaviour:
- Reset (async, rst=0): state=IDLE.
  - Outputs: coin_req=0, coin_sel=0, remaining=0, busy=0, done=0, insufficient=0, fault=0.
  - coin_req drops immediately, without waiting for clk.
- All outputs are registered Moore outputs. Arithmetic is 8-bit unsigned; subtraction is performed only after a compare guarantees no underflow.
- IDLE:
  - start=1 at edge N: latch credit/price, clear fault, go to CHECK.
  - start is ignored in all other states.
- CHECK, edge N+1:
  - If credit < price: go to ERR; remaining=0.
  - Else: remaining = credit - price; go to SELECT.
- SELECT, edge N+2:
  - If remaining=0: go to DONE.
  - Else: coin_sel = lowest index i with COINi <= remaining; coin_req=1; clear timeout counter; go to REQ.
- REQ: hold coin_req=1 and coin_sel stable.
  - coin_ack=1 sampled: remaining -= COIN[coin_sel]; coin_req=0; go to WAIT_REL.
  - Otherwise the counter increments. When the counter reaches ACK_TIMEOUT: coin_req=0, fault=1, go to FAULT.
- WAIT_REL:
  - Wait for coin_ack=0, then go to SELECT.
  - A new coin_req is never raised while coin_ack is still high (full 4-phase handshake).
- DONE: done=1 for exactly one cycle, remaining=0, then IDLE.
- ERR: insufficient=1 for exactly one cycle, then IDLE.
- FAULT:
  - Go to IDLE next cycle.
  - fault stays 1; remaining keeps the unpaid amount for diagnostics.
- Boundary conditions:
  - coin_ack already high when REQ is entered counts as an ack. The ejector contract forbids this; WAIT_REL prevents it internally.
  - credit=price: no coins paid; done is asserted at edge N+2 (2 cycles after start).
  - credit=255, price=0: 50×5, 5×1 → coin_sel sequence 0,0,0,0,0,3; no 8-bit overflow.
  - Reset mid-dispense: abort. Coins already ejected are not tracked; remaining=0.
  - start held high continuously: after done/insufficient, a new transaction begins on the first IDLE cycle.

Test Plan:
- credit=100, price=37, ejector acks 2 cycles after each req and releases 1 cycle later → coin_sel sequence 0,2,4,4,4; remaining 63→13→3→2→1→0; one done pulse; busy low afterwards.
- credit=20, price=30 → insufficient pulse at edge N+1, coin_req never asserted, remaining=0, done=0.
- credit=45, price=45 → done pulse at edge N+2 with no coin_req; start=1 pulsed again while busy (previous run) is ignored.
- credit=60, price=0, coin_ack held 0 → coin_req high exactly ACK_TIMEOUT=16 cycles, then coin_req=0, fault=1 sticky, remaining=60; the next start clears fault.
- credit=90, price=5: assert rst=0 while coin_req=1 for the second coin → coin_req, busy, and remaining go to 0 asynchronously; after release a new start with credit=10, price=0 pays coin_sel=2 and completes.
- Ejector holds coin_ack high for 5 cycles → no new coin_req until coin_ack=0; remaining decremented exactly once per coin.
